// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_STALL  = 2'd1,
    ST_FLUSH  = 2'd2,
    ST_FREEZE = 2'd3
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam int CNT_W = 16;
  localparam int RUN_W = 8;

  typedef struct packed {
    logic pc_write;
    logic if_id_write;
    logic id_ex_bubble;
    logic flush_if_id;
    logic flush_id_ex;
    logic flush_ex_mem;
    logic pipe_freeze;
  } ctl_t;

  // Only these formats actually read rt as a source operand.
  function automatic logic rt_used(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_BEQ) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/hazard_unit_sat_counter.sv
// Saturating up-counter with synchronous clear taking priority over increment.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)               cnt <= '0;
    else if (clr)             cnt <= '0;
    else if (inc && !(&cnt))  cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard controller: picks one of RUN/STALL/FLUSH/FREEZE per cycle
// and drives stage enables/flushes combinationally, with event counters.
module hazard_unit
  import hazard_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       if_id_rs,
  input  logic [4:0]       if_id_rt,
  input  logic [5:0]       if_id_opcode,
  input  logic             id_ex_memread,
  input  logic [4:0]       id_ex_rt,
  input  logic             branch_taken,
  input  logic             mem_busy,
  input  logic             cnt_clr,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             id_ex_bubble,
  output logic             flush_if_id,
  output logic             flush_id_ex,
  output logic             flush_ex_mem,
  output logic             pipe_freeze,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] freeze_cnt,
  output logic             freeze_timeout
);

  state_e            state_q, action;
  ctl_t              ctl;
  logic              load_use;
  logic              act_stall, act_freeze;
  logic [RUN_W-1:0]  freeze_run;

  assign load_use = id_ex_memread && (id_ex_rt != 5'd0) &&
                    ((id_ex_rt == if_id_rs) ||
                     ((id_ex_rt == if_id_rt) && rt_used(if_id_opcode)));

  // State register simply records the action taken this cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_RUN;
    else        state_q <= action;
  end

  // A load is allowed at most one bubble: STALL masks load_use next cycle.
  always_comb begin
    action = ST_RUN;
    if (mem_busy)                             action = ST_FREEZE;
    else if (branch_taken)                    action = ST_FLUSH;
    else if (load_use && state_q != ST_STALL) action = ST_STALL;
  end

  always_comb begin
    ctl = '0;
    unique case (action)
      ST_RUN: begin
        ctl.pc_write    = 1'b1;
        ctl.if_id_write = 1'b1;
      end
      ST_STALL: ctl.id_ex_bubble = 1'b1;
      ST_FLUSH: begin
        ctl.pc_write     = 1'b1;
        ctl.if_id_write  = 1'b1;
        ctl.flush_if_id  = 1'b1;
        ctl.flush_id_ex  = 1'b1;
        ctl.flush_ex_mem = 1'b1;
      end
      ST_FREEZE: ctl.pipe_freeze = 1'b1;
      default: ctl = '0;
    endcase
    // Everything held quiet while reset is asserted, independent of inputs.
    if (!rst_n) ctl = '0;
  end

  assign pc_write     = ctl.pc_write;
  assign if_id_write  = ctl.if_id_write;
  assign id_ex_bubble = ctl.id_ex_bubble;
  assign flush_if_id  = ctl.flush_if_id;
  assign flush_id_ex  = ctl.flush_id_ex;
  assign flush_ex_mem = ctl.flush_ex_mem;
  assign pipe_freeze  = ctl.pipe_freeze;
  assign state        = state_q;

  assign act_stall  = (action == ST_STALL);
  assign act_freeze = (action == ST_FREEZE);

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (act_stall),
    .clr   (cnt_clr),
    .cnt   (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_freeze_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (act_freeze),
    .clr   (cnt_clr),
    .cnt   (freeze_cnt)
  );

  // Consecutive-freeze run length; any other action breaks the run.
  sat_counter #(.W(RUN_W)) u_freeze_run (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (act_freeze),
    .clr   (!act_freeze),
    .cnt   (freeze_run)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                         freeze_timeout <= 1'b0;
    else if (cnt_clr)                   freeze_timeout <= 1'b0;
    else if (act_freeze && &freeze_run) freeze_timeout <= 1'b1;
  end

endmodule

// File: tb/tb_hazard_unit.sv
// Directed-vector bench for hazard_unit; expectations queued by the driver,
// checked by an independent negedge monitor.
module tb_hazard_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  if_id_rs, if_id_rt, id_ex_rt;
  logic [5:0]  if_id_opcode;
  logic        id_ex_memread, branch_taken, mem_busy, cnt_clr;
  logic        pc_write, if_id_write, id_ex_bubble;
  logic        flush_if_id, flush_id_ex, flush_ex_mem, pipe_freeze;
  logic [1:0]  state;
  logic [15:0] stall_cnt, freeze_cnt;
  logic        freeze_timeout;

  hazard_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .if_id_rs       (if_id_rs),
    .if_id_rt       (if_id_rt),
    .if_id_opcode   (if_id_opcode),
    .id_ex_memread  (id_ex_memread),
    .id_ex_rt       (id_ex_rt),
    .branch_taken   (branch_taken),
    .mem_busy       (mem_busy),
    .cnt_clr        (cnt_clr),
    .pc_write       (pc_write),
    .if_id_write    (if_id_write),
    .id_ex_bubble   (id_ex_bubble),
    .flush_if_id    (flush_if_id),
    .flush_id_ex    (flush_id_ex),
    .flush_ex_mem   (flush_ex_mem),
    .pipe_freeze    (pipe_freeze),
    .state          (state),
    .stall_cnt      (stall_cnt),
    .freeze_cnt     (freeze_cnt),
    .freeze_timeout (freeze_timeout)
  );

  always #5 clk = ~clk;

  // {pc_write, if_id_write, bubble, flush_if_id, flush_id_ex, flush_ex_mem, freeze}
  localparam logic [6:0] C_RUN = 7'b1100000;
  localparam logic [6:0] C_STL = 7'b0010000;
  localparam logic [6:0] C_FLS = 7'b1101110;
  localparam logic [6:0] C_FRZ = 7'b0000001;
  localparam logic [6:0] C_RST = 7'b0000000;

  typedef struct {
    string       nm;
    logic [6:0]  ctl;
    logic [1:0]  st;
    logic [15:0] sc;
    logic [15:0] fc;
    logic        to;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  task automatic drv(input logic mr, input logic [4:0] ert, input logic [4:0] rs,
                     input logic [4:0] rt, input logic [5:0] op, input logic br,
                     input logic busy, input logic clr);
    @(posedge clk);
    #1;
    id_ex_memread = mr;  id_ex_rt = ert;  if_id_rs = rs;  if_id_rt = rt;
    if_id_opcode  = op;  branch_taken = br;  mem_busy = busy;  cnt_clr = clr;
  endtask

  task automatic idle();
    drv(1'b0, 5'd0, 5'd0, 5'd0, 6'h00, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic expect_(input string nm, input logic [6:0] c, input logic [1:0] st,
                         input logic [15:0] sc, input logic [15:0] fc, input logic to);
    exp_t e;
    e.nm = nm; e.ctl = c; e.st = st; e.sc = sc; e.fc = fc; e.to = to;
    q.push_back(e);
  endtask

  // Monitor: pops one expectation per falling edge when any are pending.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      logic [6:0] act;
      e = q.pop_front();
      act = {pc_write, if_id_write, id_ex_bubble, flush_if_id, flush_id_ex,
             flush_ex_mem, pipe_freeze};
      total++;
      if (act !== e.ctl || state !== e.st || stall_cnt !== e.sc ||
          freeze_cnt !== e.fc || freeze_timeout !== e.to) begin
        bad++;
        $display("FAIL %s: got ctl=%b st=%0d sc=%0d fc=%0d to=%b want ctl=%b st=%0d sc=%0d fc=%0d to=%b",
                 e.nm, act, state, stall_cnt, freeze_cnt, freeze_timeout,
                 e.ctl, e.st, e.sc, e.fc, e.to);
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    id_ex_memread = 0; id_ex_rt = 0; if_id_rs = 0; if_id_rt = 0;
    if_id_opcode = 0; branch_taken = 0; mem_busy = 1'b1; cnt_clr = 0;
    expect_("reset_hold", C_RST, 2'd0, 16'd0, 16'd0, 1'b0);
    @(posedge clk); @(posedge clk);
    #1 rst_n = 1'b1; mem_busy = 1'b0;

    idle();                                              expect_("run0", C_RUN, 0, 0, 0, 0);
    // load-use on rs: one stall then proceed
    drv(1, 5'd2, 5'd2, 5'd0, 6'h23, 0, 0, 0);            expect_("lu_c1", C_STL, 0, 0, 0, 0);
    drv(1, 5'd2, 5'd2, 5'd0, 6'h23, 0, 0, 0);            expect_("lu_c2", C_RUN, 1, 1, 0, 0);
    idle();                                              expect_("lu_after", C_RUN, 0, 1, 0, 0);
    drv(1, 5'd0, 5'd0, 5'd0, 6'h00, 0, 0, 0);            expect_("rt_zero", C_RUN, 0, 1, 0, 0);
    drv(1, 5'd5, 5'd1, 5'd5, 6'h23, 0, 0, 0);            expect_("rt_lw", C_RUN, 0, 1, 0, 0);
    drv(1, 5'd5, 5'd1, 5'd5, 6'h04, 0, 0, 0);            expect_("rt_beq", C_STL, 0, 1, 0, 0);
    idle();                                              expect_("beq_after", C_RUN, 1, 2, 0, 0);
    drv(1, 5'd5, 5'd1, 5'd5, 6'h2B, 0, 0, 0);            expect_("rt_sw", C_STL, 0, 2, 0, 0);
    idle();                                              expect_("sw_after", C_RUN, 1, 3, 0, 0);
    // branch beats load-use
    drv(1, 5'd3, 5'd3, 5'd0, 6'h00, 1, 0, 0);            expect_("lu_br", C_FLS, 0, 3, 0, 0);
    idle();                                              expect_("br_after", C_RUN, 2, 3, 0, 0);
    // branch during freeze resolves after memory is ready
    drv(0, 5'd0, 5'd0, 5'd0, 6'h00, 1, 1, 0);            expect_("frzbr1", C_FRZ, 0, 3, 0, 0);
    drv(0, 5'd0, 5'd0, 5'd0, 6'h00, 1, 1, 0);            expect_("frzbr2", C_FRZ, 3, 3, 1, 0);
    drv(0, 5'd0, 5'd0, 5'd0, 6'h00, 1, 1, 0);            expect_("frzbr3", C_FRZ, 3, 3, 2, 0);
    drv(0, 5'd0, 5'd0, 5'd0, 6'h00, 1, 0, 0);            expect_("frzbr_fl", C_FLS, 3, 3, 3, 0);
    idle();                                              expect_("frzbr_run", C_RUN, 2, 3, 3, 0);
    drv(1, 5'd4, 5'd4, 5'd0, 6'h00, 0, 1, 0);            expect_("frz_over_lu", C_FRZ, 0, 3, 3, 0);
    idle();                                              expect_("frz_lu_after", C_RUN, 3, 3, 4, 0);
    drv(0, 5'd0, 5'd0, 5'd0, 6'h00, 0, 0, 1);            expect_("clr1", C_RUN, 0, 3, 4, 0);
    idle();                                              expect_("clr1_after", C_RUN, 0, 0, 0, 0);
    // long freeze: timeout after the 256th consecutive freeze
    for (int i = 0; i < 300; i++) begin
      drv(0, 5'd0, 5'd0, 5'd0, 6'h00, 0, 1, 0);
      expect_($sformatf("long_frz_%0d", i), C_FRZ, (i == 0) ? 2'd0 : 2'd3,
              16'd0, 16'(i), (i >= 256));
    end
    idle();                                              expect_("long_end", C_RUN, 3, 0, 300, 1);
    idle();                                              expect_("to_sticky", C_RUN, 0, 0, 300, 1);
    drv(0, 5'd0, 5'd0, 5'd0, 6'h00, 0, 0, 1);            expect_("clr2", C_RUN, 0, 0, 300, 1);
    idle();                                              expect_("clr2_after", C_RUN, 0, 0, 0, 0);
    drv(0, 5'd0, 5'd0, 5'd0, 6'h00, 0, 1, 1);            expect_("clr_vs_inc", C_FRZ, 0, 0, 0, 0);
    idle();                                              expect_("clr_wins", C_RUN, 3, 0, 0, 0);
    // asynchronous reset mid-freeze
    drv(0, 5'd0, 5'd0, 5'd0, 6'h00, 0, 1, 0);            expect_("pre_rst1", C_FRZ, 0, 0, 0, 0);
    drv(0, 5'd0, 5'd0, 5'd0, 6'h00, 0, 1, 0);            expect_("pre_rst2", C_FRZ, 3, 0, 1, 0);
    @(posedge clk);
    #1 rst_n = 1'b0;                                     expect_("async_rst", C_RST, 0, 0, 0, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;                                     expect_("post_rst", C_FRZ, 0, 0, 0, 0);
    idle();                                              expect_("post_rst_run", C_RUN, 3, 0, 1, 0);

    repeat (3) @(posedge clk);
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain: pending=%0d want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: sim time limit reached, want finish earlier");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/hazard_unit.md
HAZARD_UNIT -- requirements
Module: hazard_unit

Interface
REQ-001 SHALL have ports: clk  in  1  single clock, rising edge.
REQ-002 SHALL have: rst_n  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have: if_id_rs, if_id_rt  in  5 each  source register fields of the instruction in ID.
REQ-004 SHALL have: if_id_opcode  in  6  opcode of the instruction in ID.
REQ-005 SHALL have: id_ex_memread  in  1, id_ex_rt  in  5  load flag and destination of the instruction in EX.
REQ-006 SHALL have: branch_taken  in  1  taken branch resolved in MEM; held stable by upstream while frozen.
REQ-007 SHALL have: mem_busy  in  1  data memory not ready this cycle.
REQ-008 SHALL have: cnt_clr  in  1  synchronous clear of counters and timeout flag.
REQ-009 SHALL have: pc_write, if_id_write  out  1  PC and IF/ID register enables.
REQ-010 SHALL have: id_ex_bubble  out  1  zero ID/EX control fields.
REQ-011 SHALL have: flush_if_id, flush_id_ex, flush_ex_mem  out  1  squash stage registers.
REQ-012 SHALL have: pipe_freeze  out  1  hold ID/EX, EX/MEM, MEM/WB.
REQ-013 SHALL have: state  out  2  current state; stall_cnt, freeze_cnt  out  16; freeze_timeout  out  1 sticky.

Function
REQ-014 SHALL compute one action per cycle with priority FREEZE (mem_busy=1) > FLUSH (branch_taken=1) > STALL (load_use=1 and state!=STALL) > RUN.
REQ-015 SHALL define load_use = id_ex_memread && id_ex_rt!=0 && (id_ex_rt==if_id_rs || (id_ex_rt==if_id_rt && rt_used)).
REQ-016 SHALL define rt_used = 1 only for opcodes 6'h00 (R-type), 6'h04 (beq), 6'h2B (sw).
REQ-017 RUN action SHALL drive pc_write=1, if_id_write=1, all other control outputs 0.
REQ-018 STALL action SHALL drive pc_write=0, if_id_write=0, id_ex_bubble=1, flushes 0, pipe_freeze=0.
REQ-019 FLUSH action SHALL drive pc_write=1, if_id_write=1, all three flushes=1, id_ex_bubble=0, pipe_freeze=0.
REQ-020 FREEZE action SHALL drive pc_write=0, if_id_write=0, pipe_freeze=1, bubble and flushes 0.
REQ-021 Control outputs SHALL be combinational from inputs and state (zero latency); state register SHALL load the current action at each rising edge.
REQ-022 States SHALL be RUN=0, STALL=1, FLUSH=2, FREEZE=3; no other encodings reachable.
REQ-023 In STALL state, load_use SHALL be masked for exactly one cycle (at most one stall cycle per load).
REQ-024 Branch during freeze SHALL produce the flush in the first cycle with mem_busy=0.
REQ-025 stall_cnt SHALL increment per STALL action, freeze_cnt per FREEZE action, both saturating at 16'hFFFF.
REQ-026 cnt_clr SHALL zero both counters and freeze_timeout at the edge, overriding any same-cycle increment.
REQ-027 Internal 8-bit freeze_run SHALL count consecutive FREEZE actions, saturate at 255, and zero on any non-FREEZE action.
REQ-028 freeze_timeout SHALL set at the edge ending a FREEZE action with freeze_run==255 (the 256th consecutive) and stay set until cnt_clr or reset.

Reset
REQ-029 While rst_n=0: state=RUN, counters=0, freeze_run=0, freeze_timeout=0, pc_write=0, if_id_write=0, all other control outputs 0.
REQ-030 Reset asserted mid-FREEZE or mid-STALL SHALL abort immediately; first post-reset action SHALL follow REQ-014 from inputs alone.

Structure
REQ-031 Package hazard_pkg SHALL hold state encodings, opcode constants OP_RTYPE/OP_BEQ/OP_SW, counter widths (16, 8).
REQ-032 Sub-module sat_counter (parameterised width, inc, clr) SHALL be instantiated for stall_cnt and freeze_cnt.

Verification
REQ-033 id_ex_memread=1, id_ex_rt=2, if_id_rs=2, inputs held 2 cycles -> cycle1 pc_write=0, if_id_write=0, id_ex_bubble=1; cycle2 RUN outputs; stall_cnt=1.
REQ-034 id_ex_rt=0 with rs=0 -> no stall; id_ex_rt=5=if_id_rt with opcode 6'h23 -> no stall; same with 6'h04 -> stall.
REQ-035 load_use and branch_taken in same cycle -> flushes=1, bubble=0, stall_cnt unchanged, state=FLUSH next.
REQ-036 mem_busy=1 for 3 cycles with branch_taken=1 -> 3 freeze cycles, freeze_cnt=3, then one flush cycle.
REQ-037 mem_busy held 300 cycles -> freeze_timeout=0 through edge 255, 1 after edge 256, freeze_cnt=300; cnt_clr -> all 0.
REQ-038 rst_n low mid-freeze -> outputs/state/counters reset immediately, without a clock edge.
